// File: rtl/cla_serial_addsub.sv
// cla_serial_addsub: WIDTH-bit add/subtract computed one 4-bit carry-lookahead slice per cycle, LSB slice first
module cla_serial_addsub #(
    parameter int WIDTH = 16,
    localparam int NSLICE = WIDTH / 4,
    localparam int KW = $clog2(NSLICE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic [WIDTH-1:0] ra, rb;
    logic carry;
    logic [KW-1:0] idx;
    logic [3:0] g, p, s;
    logic [4:0] c;
    always_comb begin
        g = ra[3:0] & rb[3:0];
        p = ra[3:0] ^ rb[3:0];
        c[0] = carry;
        c[1] = g[0] | (p[0] & carry);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) | (&p & carry);
        s = p ^ c[3:0];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ra <= '0;
            rb <= '0;
            carry <= 1'b0;
            idx <= '0;
            sum <= '0;
            cout <= 1'b0;
            ovf <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    ra <= a;
                    rb <= b ^ {WIDTH{sub}};
                    carry <= cin ^ sub;
                    idx <= '0;
                    sum <= '0;
                    state <= RUN;
                end
                RUN: begin
                    // operands shift down so the slice always reads the low nibble
                    sum[{idx, 2'b00} +: 4] <= s;
                    ra <= ra >> 4;
                    rb <= rb >> 4;
                    carry <= c[4];
                    idx <= idx + 1'b1;
                    if (idx == KW'(NSLICE - 1)) begin
                        cout <= c[4];
                        ovf <= c[3] ^ c[4];
                        state <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;
    assign busy = state != IDLE;
endmodule
